lsu_mem_responder: RTL and testbench

// Memory-side responder for the four PE-row LSU request ports. Captures read/write

---
 rtl/lsu_mem_responder_if.sv | 19 +
 rtl/lsu_mem_responder.sv | 157 +++++++++++++++
 tb/tb_lsu_mem_responder.sv | 239 +++++++++++++++++++++++
 3 files changed

// File: rtl/lsu_mem_responder_if.sv
// Row-side bundle between the PE-row LSUs and the memory responder.
// One bit / bus per row; packed by row index.
interface lsu_mem_responder_if #(
  parameter int NUM_ROWS = 4,
  parameter int ADDR_W   = 16,
  parameter int DATA_W   = 32
);
  logic [NUM_ROWS-1:0]                    r_request;
  logic [NUM_ROWS-1:0]                    w_request;
  logic [NUM_ROWS-1:0][ADDR_W+DATA_W-1:0] lsu_addr_bus;
  logic [NUM_ROWS-1:0][DATA_W:0]          cbg_to_lsu_bus;
  logic [NUM_ROWS-1:0]                    busy;
  logic [NUM_ROWS-1:0]                    drop;

  modport master (output r_request, w_request, lsu_addr_bus,
                  input  cbg_to_lsu_bus, busy, drop);
  modport slave  (input  r_request, w_request, lsu_addr_bus,
                  output cbg_to_lsu_bus, busy, drop);
endinterface

// File: rtl/lsu_mem_responder.sv
// Memory-side responder: per-row depth-1 request slots, round-robin arbitration onto
// one single-port SRAM, read data returned to the requesting row three edges later.

module lsu_slot #(
  parameter int ADDR_W = 16,
  parameter int DATA_W = 32
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     r_req,
  input  logic                     w_req,
  input  logic [ADDR_W+DATA_W-1:0] bus,
  input  logic                     gnt,
  output logic                     pend,
  output logic                     is_rd,
  output logic [ADDR_W-1:0]        addr,
  output logic [DATA_W-1:0]        wdata,
  output logic                     drop
);
  typedef enum logic {EMPTY, PEND} st_t;
  st_t  st, st_nxt;
  logic cap, drop_nxt;

  always_ff @(posedge clk or negedge rst)
    if (!rst) st <= EMPTY;
    else      st <= st_nxt;

  always_comb begin
    st_nxt = st;
    case (st)
      EMPTY: if (r_req || w_req) st_nxt = PEND;
      PEND:  if (gnt)            st_nxt = EMPTY;
      default:                   st_nxt = EMPTY;
    endcase
  end

  // A request landing on a full slot is lost, as is the read half of R&W.
  always_comb begin
    pend     = (st == PEND);
    cap      = (st == EMPTY) && (r_req || w_req);
    drop_nxt = (r_req || w_req) && ((st == PEND) || (r_req && w_req));
  end

  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      is_rd <= 1'b0;
      addr  <= '0;
      wdata <= '0;
      drop  <= 1'b0;
    end else begin
      drop <= drop_nxt;
      if (cap) begin
        is_rd <= ~w_req;
        addr  <= bus[ADDR_W-1:0];
        wdata <= bus[ADDR_W+:DATA_W];
      end
    end
endmodule

module lsu_mem_responder #(
  parameter int NUM_ROWS = 4,
  parameter int ADDR_W   = 16,
  parameter int DATA_W   = 32
) (
  input  logic              clk,
  input  logic              rst,
  lsu_mem_responder_if.slave lsu,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              idle
);
  localparam int RW     = $clog2(NUM_ROWS);
  localparam int STAGES = 1;

  logic [NUM_ROWS-1:0]             pend, is_rd, gnt;
  logic [NUM_ROWS-1:0][ADDR_W-1:0] s_addr;
  logic [NUM_ROWS-1:0][DATA_W-1:0] s_wdata;
  logic [NUM_ROWS-1:0]             ret_vld;
  logic [NUM_ROWS-1:0][DATA_W-1:0] ret_data;

  logic          gnt_vld;
  logic [RW-1:0] gnt_idx, ptr, ptr_nxt;
  int            arb_j;

  // Stage 0 is the SRAM access cycle, stage STAGES the cycle mem_rdata is valid.
  logic [STAGES:0]         vld_pipe, rd_pipe;
  logic [STAGES:0][RW-1:0] row_pipe;

  for (genvar g = 0; g < NUM_ROWS; g++) begin : g_row
    lsu_slot #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) u_slot (
      .clk   (clk),
      .rst   (rst),
      .r_req (lsu.r_request[g]),
      .w_req (lsu.w_request[g]),
      .bus   (lsu.lsu_addr_bus[g]),
      .gnt   (gnt[g]),
      .pend  (pend[g]),
      .is_rd (is_rd[g]),
      .addr  (s_addr[g]),
      .wdata (s_wdata[g]),
      .drop  (lsu.drop[g])
    );
    assign gnt[g]                = gnt_vld && (gnt_idx == RW'(g));
    assign lsu.cbg_to_lsu_bus[g] = {ret_vld[g], ret_data[g]};
  end

  assign lsu.busy = pend;
  assign mem_en   = vld_pipe[0];
  assign idle     = ~|pend && ~|vld_pipe;

  // First pending slot at or above the pointer, wrapping.
  always_comb begin
    gnt_vld = 1'b0;
    gnt_idx = '0;
    arb_j   = 0;
    for (int i = 0; i < NUM_ROWS; i++) begin
      arb_j = (int'(ptr) + i) % NUM_ROWS;
      if (!gnt_vld && pend[arb_j]) begin
        gnt_vld = 1'b1;
        gnt_idx = RW'(arb_j);
      end
    end
  end

  assign ptr_nxt = (gnt_idx == RW'(NUM_ROWS-1)) ? '0 : gnt_idx + 1'b1;

  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      vld_pipe  <= '0;
      rd_pipe   <= '0;
      row_pipe  <= '0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      ptr       <= '0;
      ret_vld   <= '0;
      ret_data  <= '0;
    end else begin
      vld_pipe <= {vld_pipe[STAGES-1:0], gnt_vld};
      rd_pipe  <= {rd_pipe[STAGES-1:0], gnt_vld & is_rd[gnt_idx]};
      row_pipe <= {row_pipe[STAGES-1:0], gnt_idx};
      mem_we   <= gnt_vld & ~is_rd[gnt_idx];
      if (gnt_vld) begin
        mem_addr  <= s_addr[gnt_idx];
        mem_wdata <= s_wdata[gnt_idx];
        ptr       <= ptr_nxt;
      end
      ret_vld <= '0;
      if (vld_pipe[STAGES] && rd_pipe[STAGES]) begin
        ret_vld[row_pipe[STAGES]]  <= 1'b1;
        ret_data[row_pipe[STAGES]] <= mem_rdata;
      end
    end
endmodule

// File: tb/tb_lsu_mem_responder.sv
// Directed bench for lsu_mem_responder: SRAM model, expected-return queue and a
// monitor that pops and compares on every CBG valid.
module tb_lsu_mem_responder;
  localparam int NR = 4;
  localparam int AW = 16;
  localparam int DW = 32;

  logic          clk, rst;
  logic          mem_en, mem_we, idle;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata, mem_rdata;
  logic [31:0]   sram [0:255];

  typedef struct { int row; logic [31:0] data; } exp_t;
  exp_t q[$];
  int   n_checks, n_fail, wr_cnt, wr0;

  lsu_mem_responder_if #(.NUM_ROWS(NR), .ADDR_W(AW), .DATA_W(DW)) lsu ();

  lsu_mem_responder #(.NUM_ROWS(NR), .ADDR_W(AW), .DATA_W(DW)) dut (
    .clk(clk), .rst(rst), .lsu(lsu),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .idle(idle)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input int row, input logic r, input logic w,
                         input logic [AW-1:0] a, input logic [DW-1:0] d);
    lsu.r_request[row]    = r;
    lsu.w_request[row]    = w;
    lsu.lsu_addr_bus[row] = {d, a};
  endtask

  task automatic clr();
    lsu.r_request = '0;
    lsu.w_request = '0;
  endtask

  task automatic chk_reset_state(input string tag);
    chk({tag, "_mem_en"}, mem_en, 0);
    chk({tag, "_mem_we"}, mem_we, 0);
    chk({tag, "_mem_addr"}, mem_addr, 0);
    chk({tag, "_mem_wdata"}, mem_wdata, 0);
    chk({tag, "_busy"}, lsu.busy, 0);
    chk({tag, "_drop"}, lsu.drop, 0);
    chk({tag, "_idle"}, idle, 1);
    for (int k = 0; k < NR; k++) chk({tag, "_cbg"}, lsu.cbg_to_lsu_bus[k], 0);
  endtask

  task automatic drain();
    int n;
    n = 0;
    while ((q.size() != 0 || !idle) && n < 40) begin
      step();
      n++;
    end
    chk("drain_timeout", (n < 40), 1);
    chk("drain_idle", idle, 1);
  endtask

  initial begin
    n_checks = 0; n_fail = 0; wr_cnt = 0;
    rst = 1'b0;
    lsu.r_request = '0; lsu.w_request = '0; lsu.lsu_addr_bus = '0;
    for (int i = 0; i < 256; i++) sram[i] <= 32'h0;
    sram[8'h10] <= 32'hDEADBEEF;
    for (int k = 0; k < NR; k++) begin
      sram[8'h20 + k] <= 32'hA000_0000 + k;
      sram[8'h30 + k] <= 32'h3000_0000 + 32'h0101_0000 * k;
    end
    mem_rdata <= '0;

    fork
      forever begin
        @(posedge clk);
        if (mem_en) begin
          if (mem_we) sram[mem_addr[7:0]] <= mem_wdata;
          else        mem_rdata <= sram[mem_addr[7:0]];
        end
      end
      forever begin
        @(negedge clk);
        if (mem_en && mem_we) wr_cnt++;
        if (rst) begin
          for (int k = 0; k < NR; k++) begin
            if (lsu.cbg_to_lsu_bus[k][DW]) begin
              if (q.size() == 0) chk("unexpected_return_row", k, 99);
              else begin
                exp_t e;
                e = q.pop_front();
                chk("return_row", k, e.row);
                chk("return_data", lsu.cbg_to_lsu_bus[k][DW-1:0], e.data);
              end
            end
          end
        end
      end
    join_none

    #12;
    chk_reset_state("rst0");
    step();
    rst = 1'b1;
    step();

    // all four rows read together, pointer at 0
    for (int k = 0; k < NR; k++) begin
      set_req(k, 1, 0, 16'h0020 + 16'(k), 0);
      q.push_back('{k, 32'hA000_0000 + k});
    end
    step();
    clr();
    chk("cont_busy", lsu.busy, 4'hF);
    chk("cont_no_en_c0", mem_en, 0);
    for (int k = 0; k < NR; k++) begin
      step();
      chk("cont_en", mem_en, 1);
      chk("cont_addr", mem_addr, 16'h0020 + 16'(k));
    end
    step();
    chk("cont_en_off", mem_en, 0);
    drain();

    // busy/drop: row 1 requests twice while row 0 is granted first
    set_req(0, 1, 0, 16'h0030, 0);
    set_req(1, 1, 0, 16'h0031, 0);
    q.push_back('{0, 32'h3000_0000});
    q.push_back('{1, 32'h3101_0000});
    step();
    lsu.r_request[0] = 1'b0;
    chk("bd_busy", lsu.busy, 4'b0011);
    step();
    clr();
    chk("bd_drop", lsu.drop, 4'b0010);
    chk("bd_busy1_held", lsu.busy, 4'b0010);
    chk("bd_addr0", mem_addr, 16'h0030);
    step();
    chk("bd_drop_once", lsu.drop, 0);
    chk("bd_busy1_free", lsu.busy, 0);
    chk("bd_addr1", mem_addr, 16'h0031);
    drain();

    // single read row 2, latency check
    set_req(2, 1, 0, 16'h0010, 0);
    q.push_back('{2, 32'hDEADBEEF});
    step();
    clr();
    chk("sr_busy", lsu.busy, 4'b0100);
    step();
    chk("sr_en", mem_en, 1);
    chk("sr_we", mem_we, 0);
    chk("sr_addr", mem_addr, 16'h0010);
    step();
    chk("sr_en_off", mem_en, 0);
    chk("sr_no_early_vld", lsu.cbg_to_lsu_bus[2][DW], 0);
    step();
    chk("sr_c3_bus2", lsu.cbg_to_lsu_bus[2], {1'b1, 32'hDEADBEEF});
    chk("sr_c3_others", {lsu.cbg_to_lsu_bus[3][DW], lsu.cbg_to_lsu_bus[1][DW],
                         lsu.cbg_to_lsu_bus[0][DW]}, 0);
    step();
    chk("sr_hold", lsu.cbg_to_lsu_bus[2], {1'b0, 32'hDEADBEEF});
    drain();

    // write then read on row 0; read issued in the cycle busy falls
    wr0 = wr_cnt;
    set_req(0, 0, 1, 16'h0005, 32'h0000_1234);
    step();
    clr();
    chk("wr_busy", lsu.busy, 4'b0001);
    step();
    chk("wr_en", mem_en, 1);
    chk("wr_we", mem_we, 1);
    chk("wr_addr", mem_addr, 16'h0005);
    chk("wr_data", mem_wdata, 32'h0000_1234);
    chk("wr_busy_free", lsu.busy, 0);
    set_req(0, 1, 0, 16'h0005, 0);
    q.push_back('{0, 32'h0000_1234});
    step();
    clr();
    chk("rd_after_free_busy", lsu.busy, 4'b0001);
    drain();
    chk("wr_count", wr_cnt - wr0, 1);

    // R&W on row 3: write wins, read lost
    wr0 = wr_cnt;
    set_req(3, 1, 1, 16'h0040, 32'hCAFE_F00D);
    step();
    clr();
    chk("rw_drop", lsu.drop, 4'b1000);
    chk("rw_busy", lsu.busy, 4'b1000);
    step();
    chk("rw_we", mem_we, 1);
    chk("rw_addr", mem_addr, 16'h0040);
    chk("rw_drop_once", lsu.drop, 0);
    drain();
    chk("rw_wr_count", wr_cnt - wr0, 1);
    set_req(3, 1, 0, 16'h0040, 0);
    q.push_back('{3, 32'hCAFE_F00D});
    step();
    clr();
    drain();

    // reset while a read is in flight
    set_req(1, 1, 0, 16'h0010, 0);
    step();
    clr();
    step();
    chk("mr_en_before_rst", mem_en, 1);
    #2;
    rst = 1'b0;
    #1;
    chk_reset_state("rst1");
    step();
    rst = 1'b1;
    repeat (6) step();
    chk("mr_idle", idle, 1);

    chk("queue_empty", q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
